// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: state encoding and
// frame-format limits.
package uart_rx_pkg;

  localparam int PRESC_MIN    = 4;
  localparam int DATA_LEN_MIN = 5;
  localparam int DATA_LEN_MAX = 9;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;
  localparam logic [2:0] ST_BREAK  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP1  = ST_STOP1,
    S_STOP2  = ST_STOP2,
    S_BREAK  = ST_BREAK
  } rx_state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len < 4'(DATA_LEN_MIN)) return 4'(DATA_LEN_MIN);
    if (len > 4'(DATA_LEN_MAX)) return 4'(DATA_LEN_MAX);
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-tap majority vote around mid-bit.
// dec_stb/dec_bit mark the bit decision; bit_end marks the last clock of a bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  input  logic               rx_s,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               bit_end,
  output logic               dec_stb,
  output logic               dec_bit
);

  logic [PRESC_W-1:0] half;
  logic               s0, s1;

  assign half = presc >> 1;

  // Third tap is taken live so the decision is ready even when P/2+1 == P-1.
  assign bit_end = run && (edge_cnt == presc - PRESC_W'(1));
  assign dec_stb = run && (edge_cnt == half + PRESC_W'(1));
  assign dec_bit = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
    end else begin
      if (!run || bit_end) edge_cnt <= '0;
      else                 edge_cnt <= edge_cnt + PRESC_W'(1);
      if (run && edge_cnt == half - PRESC_W'(1)) s0 <= rx_s;
      if (run && edge_cnt == half)               s1 <= rx_s;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchroniser, frame FSM, deserialiser and
// parity/stop/break checking with single-cycle status pulses.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W_MAX = 9,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [3:0]            data_len,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stp_two,
  output logic [DATA_W_MAX-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_err,
  output logic                  brk_det,
  output logic [2:0]            dbg_state
);

  rx_state_t             state, state_nxt;
  logic                  rx_meta, rx_s;
  logic [PRESC_W-1:0]    presc_q, presc_eff, edge_cnt;
  logic [3:0]            len_q, bit_cnt;
  logic                  par_en_q, par_type_q, stp_two_q, par_bit_q;
  logic [DATA_W_MAX-1:0] shift_q;
  logic                  run, bit_end, dec_stb, dec_bit;
  logic                  start_frame, shift_en, bit_adv, par_cap;
  logic                  dv_nxt, pe_nxt, se_nxt, ste_nxt, bd_nxt;
  logic                  brk_pattern, par_bad, to_brk;

  assign dbg_state = state;
  assign run = (state != S_IDLE) && (state != S_BREAK);
  assign presc_eff = (prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN) : prescale;

  // Unused high shift bits stay 0, so whole-register reductions are safe.
  assign brk_pattern = (shift_q == '0) && (!par_en_q || !par_bit_q);
  assign par_bad     = ((^shift_q) ^ par_bit_q) != par_type_q;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .presc    (presc_q),
    .rx_s     (rx_s),
    .edge_cnt (edge_cnt),
    .bit_end  (bit_end),
    .dec_stb  (dec_stb),
    .dec_bit  (dec_bit)
  );

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    bit_adv     = 1'b0;
    par_cap     = 1'b0;
    to_brk      = 1'b0;
    dv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    se_nxt      = 1'b0;
    ste_nxt     = 1'b0;
    bd_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt   = S_START;
          start_frame = 1'b1;
        end
      end
      S_START: begin
        if (dec_stb && dec_bit) begin
          ste_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (bit_end) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        shift_en = dec_stb;
        if (bit_end) begin
          if (bit_cnt == len_q - 4'd1) state_nxt = par_en_q ? S_PARITY : S_STOP1;
          else                         bit_adv   = 1'b1;
        end
      end
      S_PARITY: begin
        par_cap = dec_stb;
        if (bit_end) state_nxt = S_STOP1;
      end
      S_STOP1, S_STOP2: begin
        if (dec_stb) begin
          if (state == S_STOP2) begin
            se_nxt = !dec_bit;
          end else if (!dec_bit && brk_pattern) begin
            to_brk = 1'b1;
            se_nxt = 1'b1;
            bd_nxt = 1'b1;
          end else begin
            se_nxt = !dec_bit;
            pe_nxt = par_en_q && par_bad;
            dv_nxt = dec_bit && !(par_en_q && par_bad);
          end
        end
        if (to_brk) begin
          state_nxt = S_BREAK;
        end else if (bit_end) begin
          if (state == S_STOP1 && stp_two_q) begin
            state_nxt = S_STOP2;
          end else if (!rx_s) begin
            state_nxt   = S_START;
            start_frame = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      presc_q    <= PRESC_W'(PRESC_MIN);
      len_q      <= 4'(DATA_LEN_MIN);
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stp_two_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      strt_err   <= 1'b0;
      brk_det    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_meta <= RX_in;
      rx_s    <= rx_meta;
      if (start_frame) begin
        presc_q    <= presc_eff;
        len_q      <= clamp_len(data_len);
        par_en_q   <= par_en;
        par_type_q <= par_type;
        stp_two_q  <= stp_two;
        par_bit_q  <= 1'b0;
        bit_cnt    <= '0;
        shift_q    <= '0;
      end
      if (shift_en) shift_q[bit_cnt] <= dec_bit;
      if (bit_adv)  bit_cnt <= bit_cnt + 4'd1;
      if (par_cap)  par_bit_q <= dec_bit;
      if (dv_nxt)   P_DATA <= shift_q;
      data_valid <= dv_nxt;
      par_err    <= pe_nxt;
      stp_err    <= se_nxt;
      strt_err   <= ste_nxt;
      brk_det    <= bd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frames are described at bit level, the expected
// status pulses and received words are derived from the frame contents alone.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 9;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          RX_in = 1'b1;
  logic [PW-1:0] prescale = 6'd8;
  logic [3:0]    data_len = 4'd8;
  logic          par_en = 1'b0, par_type = 1'b0, stp_two = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid, par_err, stp_err, strt_err, brk_det;
  logic [2:0]    dbg_state;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [13:0]   exp_q[$];           // {dv, pe, se, ste, bd, data[8:0]}
  logic [DW-1:0] model_pdata = '0;
  logic          cmp_en = 1'b0;
  int            cfg_p = 8, cfg_len = 8;
  logic          cfg_pe = 1'b0, cfg_pt = 1'b0, cfg_s2 = 1'b0;

  uart_rx_ctrl #(.DATA_W_MAX(DW), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .RX_in(RX_in), .prescale(prescale), .data_len(data_len),
    .par_en(par_en), .par_type(par_type), .stp_two(stp_two), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .strt_err(strt_err), .brk_det(brk_det), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outcome of one frame's stop-bit decision, from frame contents only.
  function automatic logic [13:0] frame_event(input int len, input logic pe_en, input logic pt,
                                              input logic [8:0] data, input logic pbit,
                                              input logic stop1);
    logic [8:0] d;
    int         ones;
    logic       se, pe, dv;
    d = '0;
    for (int i = 0; i < len; i++) d[i] = data[i];
    ones = $countones(d);
    if (!stop1 && d == 9'd0 && (!pe_en || !pbit)) return {5'b00101, 9'd0};
    se = !stop1;
    pe = pe_en && (((ones + int'(pbit)) % 2) != int'(pt));
    dv = !se && !pe;
    return {dv, pe, se, 1'b0, 1'b0, dv ? d : 9'd0};
  endfunction

  function automatic logic good_parity(input int len, input logic pt, input logic [8:0] data);
    int ones = 0;
    for (int i = 0; i < len; i++) ones += int'(data[i]);
    return logic'((ones % 2) != 0) ^ pt;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [4:0]  flags;
    logic [13:0] e;
    if (cmp_en) begin
      flags = {data_valid, par_err, stp_err, strt_err, brk_det};
      if (flags != 5'b0) begin
        if (exp_q.size() == 0) begin
          check("spurious_pulse", 32'(flags), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_flags", 32'(flags), 32'(e[13:9]));
          if (e[13]) model_pdata = e[8:0];
        end
      end
      check("p_data", 32'(P_DATA), 32'(model_pdata));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int p, input int len, input logic pe, input logic pt, input logic s2);
    prescale = PW'(p);
    data_len = 4'(len);
    par_en   = pe;
    par_type = pt;
    stp_two  = s2;
    cfg_p    = (p < 4) ? 4 : p;
    cfg_len  = (len < 5) ? 5 : ((len > 9) ? 9 : len);
    cfg_pe   = pe;
    cfg_pt   = pt;
    cfg_s2   = s2;
  endtask

  task automatic send_bit(input logic b);
    RX_in = b;
    tick(cfg_p);
  endtask

  task automatic send_frame(input logic [8:0] data, input logic pbit, input logic stop1,
                            input logic stop2, output logic is_brk);
    logic [13:0] ev;
    ev = frame_event(cfg_len, cfg_pe, cfg_pt, data, pbit, stop1);
    is_brk = ev[9];
    exp_q.push_back(ev);
    if (!is_brk && cfg_s2 && !stop2) exp_q.push_back({5'b00100, 9'd0});
    send_bit(1'b0);
    for (int i = 0; i < cfg_len; i++) send_bit(data[i]);
    if (cfg_pe) send_bit(pbit);
    send_bit(stop1);
    if (cfg_s2) send_bit(stop2);
  endtask

  task automatic send_glitch(input int low_clks);
    exp_q.push_back({5'b00010, 9'd0});
    RX_in = 1'b0;
    tick(low_clks);
    RX_in = 1'b1;
    tick(2 * cfg_p + 4);
  endtask

  task automatic wait_drain(input string name);
    int budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    RX_in = 1'b1;
    tick(n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        brk;
    logic [8:0]  d;
    logic        pb, s1, s2;
    tick(3);
    check("rst_p_data", 32'(P_DATA), 32'd0);
    check("rst_flags", 32'({data_valid, par_err, stp_err, strt_err, brk_det}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    tick(2);
    cmp_en = 1'b1;

    // Hand-computed outcomes pinning the model.
    check("pin_a5", 32'(frame_event(8, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b1)), 32'({5'b10000, 9'h0A5}));
    check("pin_3c_par", 32'(frame_event(8, 1'b1, 1'b0, 9'h03C, 1'b1, 1'b1)), 32'({5'b01000, 9'h000}));
    check("pin_55_odd", 32'(frame_event(7, 1'b1, 1'b1, 9'h055, 1'b1, 1'b1)), 32'({5'b10000, 9'h055}));
    check("pin_2a_odd", 32'(frame_event(7, 1'b1, 1'b1, 9'h02A, 1'b0, 1'b1)), 32'({5'b10000, 9'h02A}));
    check("pin_break", 32'(frame_event(8, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0)), 32'({5'b00101, 9'h000}));

    // 8N1 at P=8
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    idle(4);
    send_frame(9'h0A5, 1'b0, 1'b1, 1'b1, brk);
    idle(8);
    wait_drain("t1_drain");
    check("t1_p_data", 32'(P_DATA), 32'h0A5);

    // even parity mismatch at P=16
    set_cfg(16, 8, 1'b1, 1'b0, 1'b0);
    send_frame(9'h03C, 1'b1, 1'b1, 1'b1, brk);
    idle(16);
    wait_drain("t2_drain");
    check("t2_p_data_held", 32'(P_DATA), 32'h0A5);

    // 3-clock glitch on the start bit
    send_glitch(3);
    wait_drain("t3_drain");
    check("t3_state", 32'(dbg_state), 32'(ST_IDLE));

    // 7O2 back-to-back at P=8
    set_cfg(8, 7, 1'b1, 1'b1, 1'b1);
    send_frame(9'h055, 1'b1, 1'b1, 1'b1, brk);
    send_frame(9'h02A, 1'b0, 1'b1, 1'b1, brk);
    idle(8);
    wait_drain("t4_drain");
    check("t4_p_data", 32'(P_DATA), 32'h02A);

    // break: line low for 12 bit-times
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({5'b00101, 9'd0});
    RX_in = 1'b0;
    tick(12 * 8);
    check("t5_in_break", 32'(dbg_state), 32'(ST_BREAK));
    idle(4);
    check("t5_left_break", 32'(dbg_state), 32'(ST_IDLE));
    wait_drain("t5_drain");
    send_frame(9'h096, 1'b0, 1'b1, 1'b1, brk);
    idle(8);
    wait_drain("t5_next_drain");
    check("t5_p_data", 32'(P_DATA), 32'h096);

    // reset in the middle of the data bits
    RX_in = 1'b0; tick(8);
    RX_in = 1'b1; tick(8);
    RX_in = 1'b0; tick(8);
    tick(3);
    rst = 1'b0;
    model_pdata = '0;
    #1;
    check("t6_p_data", 32'(P_DATA), 32'd0);
    check("t6_flags", 32'({data_valid, par_err, stp_err, strt_err, brk_det}), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    RX_in = 1'b1;
    tick(3);
    rst = 1'b1;
    idle(10);
    send_frame(9'h081, 1'b0, 1'b1, 1'b1, brk);
    idle(8);
    wait_drain("t6_drain");
    check("t6_p_data_81", 32'(P_DATA), 32'h081);

    // randomized frames, formats and line faults
    for (int n = 0; n < 60; n++) begin
      set_cfg($urandom_range(0, 20), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (cfg_p >= 8 && $urandom_range(0, 5) == 0) send_glitch($urandom_range(1, cfg_p / 2 - 1));
      do begin
        d  = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
        pb = good_parity(cfg_len, cfg_pt, d);
        if ($urandom_range(0, 4) == 0) pb = ~pb;
        s1 = ($urandom_range(0, 5) != 0);
        s2 = ($urandom_range(0, 5) != 0);
        send_frame(d, pb, s1, s2, brk);
      end while (!brk && $urandom_range(0, 2) == 0);
      idle(brk ? 2 * cfg_p + 3 : $urandom_range(1, 3 * cfg_p));
      wait_drain("rand_drain");
    end

    idle(40);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
